mem_bus_if: RTL and testbench

- Parametrised load/store/fetch bus interface between the multicycle RV32I core and an external memory with a valid/ready handshake.
- Replaces the fixed one-cycle memory assumption: the core raises a request, this block holds the bus until memory responds, and the core stalls on `busy`.
- Generates byte enables and lane-replicated write data, aligns and sign/zero-extends load data, and reports misalignment, illegal width and timeout faults.

---
 rtl/mem_bus_if.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bus_if.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// Load/store/fetch bus interface: holds a valid/ready transaction open for the
// multicycle core, builds byte enables and lane data, and extends load results.
module mem_bus_if #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic                we_q, we_nxt;
    logic [2:0]          f3_q, f3_nxt;
    logic [1:0]          off_q, off_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [31:0]         rdata_nxt;
    logic                fault_nxt;
    logic [1:0]          fault_code_nxt;
    logic                bus_valid_nxt;
    logic                bus_we_nxt;
    logic [ADDR_W-1:0]   bus_addr_nxt;
    logic [3:0]          bus_be_nxt;
    logic [31:0]         bus_wdata_nxt;
    logic                illegal;
    logic                misaligned;

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  o);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Legality is judged on the live inputs in IDLE, i.e. exactly what gets latched.
    always_comb begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                  (we && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    assign done = (state == S_DONE);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt      = state;
        we_nxt         = we_q;
        f3_nxt         = f3_q;
        off_nxt        = off_q;
        cnt_nxt        = cnt;
        rdata_nxt      = rdata;
        fault_nxt      = 1'b0;
        fault_code_nxt = 2'b00;
        bus_valid_nxt  = bus_valid;
        bus_we_nxt     = bus_we;
        bus_addr_nxt   = bus_addr;
        bus_be_nxt     = bus_be;
        bus_wdata_nxt  = bus_wdata;

        case (state)
            S_IDLE: begin
                if (req) begin
                    we_nxt  = we;
                    f3_nxt  = funct3;
                    off_nxt = addr[1:0];
                    if (illegal) begin
                        state_nxt      = S_DONE;
                        fault_nxt      = 1'b1;
                        fault_code_nxt = 2'b11;
                    end else if (misaligned) begin
                        state_nxt      = S_DONE;
                        fault_nxt      = 1'b1;
                        fault_code_nxt = 2'b01;
                    end else begin
                        state_nxt     = S_BUS;
                        cnt_nxt       = '0;
                        bus_valid_nxt = 1'b1;
                        bus_we_nxt    = we;
                        bus_addr_nxt  = {addr[ADDR_W-1:2], 2'b00};
                        if (we) begin
                            case (funct3[1:0])
                                2'b00: begin
                                    bus_be_nxt    = 4'b0001 << addr[1:0];
                                    bus_wdata_nxt = {4{wdata[7:0]}};
                                end
                                2'b01: begin
                                    bus_be_nxt    = 4'b0011 << addr[1:0];
                                    bus_wdata_nxt = {2{wdata[15:0]}};
                                end
                                default: begin
                                    bus_be_nxt    = 4'b1111;
                                    bus_wdata_nxt = wdata;
                                end
                            endcase
                        end else begin
                            bus_be_nxt    = 4'b1111;
                            bus_wdata_nxt = wdata;
                        end
                    end
                end
            end

            S_BUS: begin
                if (bus_ready) begin
                    state_nxt     = S_DONE;
                    bus_valid_nxt = 1'b0;
                    bus_we_nxt    = 1'b0;
                    rdata_nxt     = we_q ? '0 : load_ext(bus_rdata, f3_q, off_q);
                end else if (cnt == CNT_LAST) begin
                    // Counter tracks completed wait cycles, so abort on the TIMEOUT-th one.
                    state_nxt      = S_DONE;
                    bus_valid_nxt  = 1'b0;
                    bus_we_nxt     = 1'b0;
                    fault_nxt      = 1'b1;
                    fault_code_nxt = 2'b10;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            cnt        <= '0;
            rdata      <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            we_q       <= we_nxt;
            f3_q       <= f3_nxt;
            off_q      <= off_nxt;
            cnt        <= cnt_nxt;
            rdata      <= rdata_nxt;
            fault      <= fault_nxt;
            fault_code <= fault_code_nxt;
            bus_valid  <= bus_valid_nxt;
            bus_we     <= bus_we_nxt;
            bus_addr   <= bus_addr_nxt;
            bus_be     <= bus_be_nxt;
            bus_wdata  <= bus_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed plus randomized bench for mem_bus_if against a byte-lane reference model.
module tb_mem_bus_if;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int          passed;
    int          total;
    logic [31:0] exp_rdata;

    mem_bus_if #(
        .ADDR_W  (32),
        .TIMEOUT (TO),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .funct3     (funct3),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One complete transaction; memory raises ready after `delay` low cycles.
    task automatic access(input logic w, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] wd, input logic [31:0] mem,
                          input int unsigned delay, input bit noise);
        bit          ill;
        bit          mis;
        int unsigned sz;
        int unsigned o;
        logic [31:0] mask;
        logic [31:0] lane;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;

        req = 1'b1; we = w; addr = a; funct3 = f; wdata = wd;
        bus_ready = 1'b0; bus_rdata = $urandom;
        tick();
        req = 1'b0;
        if (noise) begin
            we = 1'($urandom); addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
        end

        ill = (f == 3) || (f == 6) || (f == 7) || (w && f >= 4);
        sz  = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
        mis = (a % sz) != 0;
        o   = a % 4;

        if (ill || mis) begin
            chk("idle_fault_done", 32'(done), 1);
            chk("idle_fault_flag", 32'(fault), 1);
            chk("idle_fault_code", 32'(fault_code), ill ? 3 : 1);
            chk("idle_fault_novalid", 32'(bus_valid), 0);
            chk("idle_fault_busy", 32'(busy), 1);
            chk("idle_fault_rdata_hold", rdata, exp_rdata);
            tick();
            chk("idle_fault_done_drop", 32'(done), 0);
            chk("idle_fault_busy_drop", 32'(busy), 0);
            chk("idle_fault_flag_drop", 32'(fault), 0);
            return;
        end

        if (!w)           exp_be = 15;
        else if (sz == 4) exp_be = 15;
        else              exp_be = ((1 << sz) - 1) << o;
        if (!w || sz == 4) exp_wd = wd;
        else if (sz == 1)  exp_wd = (wd & 32'hFF) * 32'h01010101;
        else               exp_wd = (wd & 32'hFFFF) * 32'h00010001;

        if (sz == 4) lane = mem;
        else begin
            mask = (sz == 1) ? 32'hFF : 32'hFFFF;
            lane = (mem >> (8 * o)) & mask;
            if (f < 4 && lane > (mask >> 1)) lane = lane - (mask + 1);
        end

        for (int k = 0; k < TO; k++) begin
            chk("bus_valid", 32'(bus_valid), 1);
            chk("bus_we", 32'(bus_we), 32'(w));
            chk("bus_addr", bus_addr, a & ~32'd3);
            chk("bus_be", 32'(bus_be), exp_be);
            if (w) chk("bus_wdata", bus_wdata, exp_wd);
            chk("busy_in_bus", 32'(busy), 1);
            chk("no_early_done", 32'(done), 0);
            bus_ready = (k >= delay);
            bus_rdata = mem;
            if (noise) req = 1'($urandom);
            if (bus_ready) begin
                tick();
                req = 1'b0; bus_ready = 1'b0; bus_rdata = $urandom;
                exp_rdata = w ? 32'd0 : lane;
                chk("ok_done", 32'(done), 1);
                chk("ok_fault", 32'(fault), 0);
                chk("ok_code", 32'(fault_code), 0);
                chk("ok_rdata", rdata, exp_rdata);
                chk("ok_valid_drop", 32'(bus_valid), 0);
                chk("ok_busy", 32'(busy), 1);
                break;
            end else if (k + 1 == TO) begin
                tick();
                req = 1'b0;
                chk("to_done", 32'(done), 1);
                chk("to_fault", 32'(fault), 1);
                chk("to_code", 32'(fault_code), 2);
                chk("to_valid_drop", 32'(bus_valid), 0);
                chk("to_rdata_hold", rdata, exp_rdata);
                break;
            end
            tick();
        end
        tick();
        chk("post_done", 32'(done), 0);
        chk("post_fault", 32'(fault), 0);
        chk("post_code", 32'(fault_code), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_rdata_hold", rdata, exp_rdata);
    endtask

    initial begin
        passed = 0; total = 0; exp_rdata = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 0; funct3 = 0; wdata = 0;
        bus_ready = 1'b0; bus_rdata = 0;
        tick(); tick();
        chk("rst_rdata", rdata, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_code", 32'(fault_code), 0);
        chk("rst_valid", 32'(bus_valid), 0);
        chk("rst_we", 32'(bus_we), 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", 32'(bus_be), 0);
        chk("rst_wdata", bus_wdata, 0);
        rst = 1'b0;
        tick();

        access(1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        access(1'b0, 32'h103, 3'b000, 32'h0, 32'h80FF0000, 0, 1'b0);
        access(1'b0, 32'h103, 3'b100, 32'h0, 32'h80FF0000, 0, 1'b0);
        access(1'b0, 32'h102, 3'b101, 32'h0, 32'h80FF0000, 1, 1'b0);
        access(1'b1, 32'h201, 3'b000, 32'h12345678, 32'h0, 3, 1'b0);
        access(1'b1, 32'h102, 3'b010, 32'hCAFEF00D, 32'h0, 0, 1'b0);
        access(1'b1, 32'h100, 3'b100, 32'hCAFEF00D, 32'h0, 0, 1'b0);
        access(1'b0, 32'h101, 3'b001, 32'h0, 32'h0, 0, 1'b0);
        access(1'b0, 32'h40, 3'b010, 32'h0, 32'h11111111, TO + 2, 1'b0);
        access(1'b0, 32'h100, 3'b010, 32'h0, 32'h5A5AA5A5, 0, 1'b0);

        // Reset in the second BUS cycle aborts with no completion.
        req = 1'b1; we = 1'b0; addr = 32'h300; funct3 = 3'b010;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        exp_rdata = 0;
        chk("rstmid_valid", 32'(bus_valid), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        rst = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        chk("rstmid_no_done1", 32'(done), 0);
        chk("rstmid_rdata", rdata, 0);
        tick();
        chk("rstmid_no_done2", 32'(done), 0);
        bus_ready = 1'b0;
        access(1'b0, 32'h304, 3'b010, 32'h0, 32'h01234567, 2, 1'b0);

        for (int i = 0; i < 80; i++) begin
            access(1'($urandom), $urandom, 3'($urandom), $urandom, $urandom,
                   $urandom_range(0, TO + 1), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
